seq_detect_param: RTL

Parametrised serial bit-pattern detector, successor to the fixed 1011 Moore detector. It matches any compile-time pattern of 2..16 bits, MSB first, with selectable overlapping or non-overlapping matching. It adds an input qualifier and an optional saturating hit counter. It sits on a serial bit stream and flags each completed match with a one-cycle registered pulse.

---
 rtl/seq_detect_param.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
//
// Serial bit-pattern detector built as a Moore FSM. It matches a compile-time
// pattern of PAT_W bits (2..16), MSB first. Matching is overlapping or
// non-overlapping, selected by OVERLAP. Each completed match produces a
// one-cycle registered pulse on `out`.
//
// Mismatches use the KMP fallback. The border table and the resulting
// transition table are folded into constants at elaboration, so the only
// runtime logic is a table lookup indexed by the current prefix length.
//
// Optional feature: define DETECT_HIT_CNT_EN to build the saturating hit
// counter together with its synchronous clear. When the macro is undefined,
// hit_cnt is tied to 0 and cnt_clr is ignored. The port list is the same in
// both builds.
//
// Parameters:
//   PAT_W    pattern length in bits (2..16)
//   PATTERN  pattern; bit PAT_W-1 is the first bit received
//   OVERLAP  1 = overlapping matches, 0 = non-overlapping
//   CNT_W    hit counter width (1..32)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_bit is consumed only when high
//   in_bit    in   serial data bit
//   cnt_clr   in   synchronous clear of hit_cnt (wins over an increment)
//   out       out  match pulse, registered, one cycle per match
//   hit_cnt   out  saturating match count (0 when the counter is not built)
// -----------------------------------------------------------------------------
module seq_detect_param #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt
);

  // Width of a prefix length 0..16.
  localparam int KW = 5;

  // Pattern bit i, counted from the first bit received.
  function automatic bit pbit(input int i);
    return PATTERN[PAT_W-1-i];
  endfunction

  // Length of the longest proper suffix of the k-bit prefix that is also a
  // prefix of the pattern.
  function automatic int border(input int k);
    int res;
    bit ok;
    res = 0;
    for (int len = 1; len < k; len++) begin
      ok = 1'b1;
      for (int i = 0; i < len; i++)
        if (pbit(i) != pbit(k - len + i)) ok = 1'b0;
      if (ok) res = len;
    end
    return res;
  endfunction

  // Prefix length reached from prefix length k (< PAT_W) after bit b.
  // On a mismatch it falls back through the borders until the bit matches
  // or the prefix is empty.
  function automatic int delta(input int k, input bit b);
    int  cur;
    int  res;
    bit  done;
    cur  = k;
    res  = 0;
    done = 1'b0;
    for (int it = 0; it <= PAT_W; it++) begin
      if (!done) begin
        if (pbit(cur) == b) begin
          res  = cur + 1;
          done = 1'b1;
        end else if (cur == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          cur = border(cur);
        end
      end
    end
    return res;
  endfunction

  // Transition table for one bit value, packed KW bits per source state.
  function automatic logic [16*KW-1:0] build_next(input bit b);
    logic [16*KW-1:0] t;
    t = '0;
    for (int k = 0; k < PAT_W; k++) t[k*KW +: KW] = KW'(delta(k, b));
    return t;
  endfunction

  localparam logic [16*KW-1:0] NEXT0  = build_next(1'b0);
  localparam logic [16*KW-1:0] NEXT1  = build_next(1'b1);
  localparam logic [KW-1:0]    FULL   = KW'(PAT_W);
  // Prefix length in effect on the cycle after a match.
  localparam logic [KW-1:0]    RESUME = OVERLAP ? KW'(border(PAT_W)) : '0;

  // The state is a phase plus a prefix length k. In MATCH, k gives the
  // matched prefix length (S0..S(PAT_W-1)). FOUND carries no prefix of its own.
  typedef enum logic {MATCH, FOUND} phase_t;

  phase_t          phase, phase_nxt;
  logic [KW-1:0]   k, k_nxt, k_eff, k_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= MATCH;
      k     <= '0;
    end else begin
      phase <= phase_nxt;
      k     <= k_nxt;
    end
  end

  always_comb begin
    phase_nxt = MATCH;
    // FOUND lasts one cycle. A bit arriving on the next edge is applied
    // from the resume point on that same edge.
    k_eff     = (phase == FOUND) ? RESUME : k;
    k_step    = in_bit ? NEXT1[k_eff*KW +: KW] : NEXT0[k_eff*KW +: KW];
    k_nxt     = k_eff;
    if (in_valid) begin
      if (k_step == FULL) begin
        phase_nxt = FOUND;
        k_nxt     = '0;
      end else begin
        k_nxt     = k_step;
      end
    end
  end

  assign out = (phase == FOUND);

`ifdef DETECT_HIT_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (cnt_clr)
      cnt <= '0;
    else if (phase_nxt == FOUND)
      cnt <= sat_inc(cnt);
  end

  assign hit_cnt = cnt;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign hit_cnt        = '0;
`endif

endmodule
